// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and helpers for the alarm unit.
//   state_t   - 2-bit FSM encoding (IDLE/ARMED/RINGING/SNOOZE)
//   MAX_MS    - largest legal minute/second value
//   inc_mod60 - minute/second increment with wrap 59 -> 0
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    localparam logic [5:0] MAX_MS = 6'd59;

    function automatic logic [5:0] inc_mod60(input logic [5:0] v);
        return (v >= MAX_MS) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/alarm_tick.sv
// alarm_tick: free-running tick generator.
//   clk, rst_n - system clock, async active-low reset
//   clr        - synchronous clear of the period counter
//   tick       - 1 for the single cycle where the counter sits at PERIOD-1
//   cnt        - current counter value (0..PERIOD-1)
module alarm_tick #(
    parameter int PERIOD = 50000000,
    localparam int CW    = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          tick,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(PERIOD - 1));
    assign cnt  = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (clr || tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/alarm_unit.sv
// alarm_unit: MM:SS alarm downstream of the min/sec counter.
//   clk, rst_n          - 50 MHz system clock, async active-low reset
//   i_min, i_sec        - running time, asynchronous to clk (2-flop synced)
//   i_alarm_en          - level, alarm armed when 1
//   i_inc_min/i_inc_sec - one-cycle pulses, bump alarm field (IDLE/ARMED only)
//   i_stop, i_snooze    - one-cycle pulses acting on RINGING/SNOOZE
//   o_alarm_min/sec     - alarm time for the display path
//   o_state, o_ringing  - FSM state and RINGING flag
//   o_buzz              - gated tone, active only while RINGING
module alarm_unit
    import alarm_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int TONE_HZ    = 1000,
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic       i_alarm_en,
    input  logic       i_inc_min,
    input  logic       i_inc_sec,
    input  logic       i_stop,
    input  logic       i_snooze,
    output logic [5:0] o_alarm_min,
    output logic [5:0] o_alarm_sec,
    output logic [1:0] o_state,
    output logic       o_ringing,
    output logic       o_buzz
);

    localparam int TONE_HALF = CLK_HZ / (2 * TONE_HZ);
    localparam int SEC_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int TONE_W    = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int SEC_MAX   = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int EL_W      = $clog2(SEC_MAX + 1);

    // ---------------- input synchronisers ----------------
    logic [5:0] min_s1, min_s2, sec_s1, sec_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_s1 <= '0;
            min_s2 <= '0;
            sec_s1 <= '0;
            sec_s2 <= '0;
        end else begin
            min_s1 <= i_min;
            min_s2 <= min_s1;
            sec_s1 <= i_sec;
            sec_s2 <= sec_s1;
        end
    end

    // ---------------- alarm time registers ----------------
    logic [5:0] alarm_min, alarm_sec;
    state_t     state, state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_min <= '0;
            alarm_sec <= '0;
        end else if (state == IDLE || state == ARMED) begin
            if (i_inc_min) alarm_min <= inc_mod60(alarm_min);
            if (i_inc_sec) alarm_sec <= inc_mod60(alarm_sec);
        end
    end

    // ---------------- match edge detect ----------------
    // Edge detection keeps a stop during the matching second from re-firing.
    logic match, match_q, match_rise;

    assign match      = (min_s2 == alarm_min) && (sec_s2 == alarm_sec);
    assign match_rise = match & ~match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) match_q <= 1'b0;
        else        match_q <= match;
    end

    // ---------------- second / tone timing ----------------
    logic              ring_entry, timed_entry;
    logic              sec_tick, tone_tick, tone;
    logic [SEC_W-1:0]  sec_cnt;
    logic [TONE_W-1:0] tone_cnt_unused;
    logic [EL_W-1:0]   elapsed;
    logic              ring_done, snooze_done, gate;

    assign ring_entry  = (state_next == RINGING) && (state != RINGING);
    assign timed_entry = ring_entry ||
                         ((state_next == SNOOZE) && (state != SNOOZE));

    alarm_tick #(.PERIOD(CLK_HZ)) u_sec_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timed_entry),
        .tick  (sec_tick),
        .cnt   (sec_cnt)
    );

    alarm_tick #(.PERIOD(TONE_HALF)) u_tone_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ring_entry),
        .tick  (tone_tick),
        .cnt   (tone_cnt_unused)
    );

    // Elapsed seconds only advance while a timed state is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            elapsed <= '0;
        else if (timed_entry)
            elapsed <= '0;
        else if (sec_tick && (state == RINGING || state == SNOOZE))
            elapsed <= elapsed + 1'b1;
    end

    assign ring_done   = sec_tick && (elapsed == EL_W'(RING_SEC - 1));
    assign snooze_done = sec_tick && (elapsed == EL_W'(SNOOZE_SEC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         tone <= 1'b0;
        else if (ring_entry) tone <= 1'b0;
        else if (tone_tick)  tone <= ~tone;
    end

    // Beep during the first half of every second since ring entry.
    assign gate = (sec_cnt < SEC_W'(CLK_HZ / 2));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!i_alarm_en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = ARMED;
                ARMED:   if (match_rise) state_next = RINGING;
                RINGING: begin
                    if (i_stop)         state_next = ARMED;
                    else if (i_snooze)  state_next = SNOOZE;
                    else if (ring_done) state_next = ARMED;
                end
                SNOOZE: begin
                    if (i_stop)           state_next = ARMED;
                    else if (snooze_done) state_next = RINGING;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        o_state     = state;
        o_ringing   = (state == RINGING);
        o_buzz      = (state == RINGING) & tone & gate;
        o_alarm_min = alarm_min;
        o_alarm_sec = alarm_sec;
    end

endmodule

// File: tb/tb_alarm_unit.sv
// Scoreboard bench for alarm_unit: stimulus pushes expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_alarm_unit;

    localparam int CLK_HZ = 100, TONE_HZ = 10, RING_SEC = 3, SNOOZE_SEC = 2;
    localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_RING = 2'd2, S_SNZ = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] i_min, i_sec;
    logic       i_alarm_en, i_inc_min, i_inc_sec, i_stop, i_snooze;
    logic [5:0] o_alarm_min, o_alarm_sec;
    logic [1:0] o_state;
    logic       o_ringing, o_buzz;

    alarm_unit #(
        .CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_min(i_min), .i_sec(i_sec),
        .i_alarm_en(i_alarm_en), .i_inc_min(i_inc_min), .i_inc_sec(i_inc_sec),
        .i_stop(i_stop), .i_snooze(i_snooze),
        .o_alarm_min(o_alarm_min), .o_alarm_sec(o_alarm_sec),
        .o_state(o_state), .o_ringing(o_ringing), .o_buzz(o_buzz)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] st;
        bit         chk_buzz;
        logic       buzz;
        bit         chk_alarm;
        logic [5:0] amin;
        logic [5:0] asec;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input string n, input logic [1:0] st, input bit cb, input logic b,
                        input bit ca, input logic [5:0] am, input logic [5:0] as);
        exp_t e;
        e.name = n; e.st = st; e.chk_buzz = cb; e.buzz = b;
        e.chk_alarm = ca; e.amin = am; e.asec = as;
        exp_q.push_back(e);
    endtask

    // Monitor: every queued expectation applies to the outputs at the next negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (o_state !== e.st) begin
                failures++;
                $display("FAIL %s state got=%0d exp=%0d", e.name, o_state, e.st);
            end
            checks++;
            if (o_ringing !== (e.st == S_RING)) begin
                failures++;
                $display("FAIL %s ringing got=%0b exp=%0b", e.name, o_ringing, e.st == S_RING);
            end
            if (e.chk_buzz) begin
                checks++;
                if (o_buzz !== e.buzz) begin
                    failures++;
                    $display("FAIL %s buzz got=%0b exp=%0b", e.name, o_buzz, e.buzz);
                end
            end
            if (e.chk_alarm) begin
                checks++;
                if (o_alarm_min !== e.amin || o_alarm_sec !== e.asec) begin
                    failures++;
                    $display("FAIL %s alarm got=%0d:%0d exp=%0d:%0d", e.name,
                             o_alarm_min, o_alarm_sec, e.amin, e.asec);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_inc(input bit m, input bit s, input int n);
        for (int i = 0; i < n; i++) begin
            i_inc_min = m;
            i_inc_sec = s;
            tick();
            i_inc_min = 1'b0;
            i_inc_sec = 1'b0;
        end
    endtask

    // From ARMED with alarm 01:05 and i_min=1: break the match, then recreate it.
    task automatic ring_again(input string n);
        i_sec = 6'd6;
        repeat (3) tick();
        i_sec = 6'd5;
        tick();
        tick();
        push({n, "_pre"}, S_ARMED, 1, 1'b0, 0, 0, 0);
        tick();
        push(n, S_RING, 1, 1'b0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_min = 6'd30; i_sec = 6'd0;
        i_alarm_en = 1'b0; i_inc_min = 1'b0; i_inc_sec = 1'b0;
        i_stop = 1'b0; i_snooze = 1'b0;

        repeat (3) tick();
        push("reset", S_IDLE, 1, 1'b0, 1, 6'd0, 6'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Setting: 61 sec pulses wrap to 1, 2 min pulses -> 2
        pulse_inc(0, 1, 61);
        pulse_inc(1, 0, 2);
        push("set_wrap", S_IDLE, 1, 1'b0, 1, 6'd2, 6'd1);
        tick();
        // Simultaneous pulses, then minute wraps 59 -> 0 -> 1: 01:05
        pulse_inc(1, 1, 4);
        pulse_inc(1, 0, 55);
        push("set_0105", S_IDLE, 1, 1'b0, 1, 6'd1, 6'd5);
        tick();

        // Arm
        i_min = 6'd1; i_sec = 6'd4; i_alarm_en = 1'b1;
        tick();
        push("armed", S_ARMED, 1, 1'b0, 0, 0, 0);
        repeat (3) tick();

        // Trigger: RINGING at the 3rd edge after i_sec becomes 5
        i_sec = 6'd5;
        tick();
        tick();
        push("trig_edge2", S_ARMED, 1, 1'b0, 0, 0, 0);
        tick();
        for (int k = 0; k < 100; k++) begin
            push($sformatf("buzz_k%0d", k), S_RING, 1, ((k % 10) >= 5) && (k < 50), 0, 0, 0);
            tick();
        end
        // Timeout at k=300
        repeat (199) tick();
        push("ring_k299", S_RING, 0, 1'b0, 0, 0, 0);
        tick();
        push("timeout", S_ARMED, 1, 1'b0, 1, 6'd1, 6'd5);
        repeat (20) tick();
        push("no_retrig", S_ARMED, 1, 1'b0, 0, 0, 0);
        tick();

        // Snooze and resume
        ring_again("ring2");
        i_snooze = 1'b1;
        tick();
        i_snooze = 1'b0;
        push("snooze", S_SNZ, 1, 1'b0, 0, 0, 0);
        repeat (199) tick();
        push("snooze_k199", S_SNZ, 1, 1'b0, 0, 0, 0);
        tick();
        push("snooze_resume", S_RING, 1, 1'b0, 0, 0, 0);
        // Setting ignored while RINGING
        pulse_inc(1, 0, 1);
        push("inc_ignored", S_RING, 0, 1'b0, 1, 6'd1, 6'd5);
        // Stop
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        push("stop", S_ARMED, 1, 1'b0, 0, 0, 0);
        tick();

        // Disable beats snooze
        ring_again("ring3");
        i_alarm_en = 1'b0;
        i_snooze = 1'b1;
        tick();
        i_snooze = 1'b0;
        push("en_prio", S_IDLE, 1, 1'b0, 0, 0, 0);
        tick();
        i_alarm_en = 1'b1;
        tick();
        push("rearm", S_ARMED, 1, 1'b0, 0, 0, 0);
        tick();

        // Async reset mid-ring
        ring_again("ring4");
        repeat (5) tick();
        push("ring4_k5", S_RING, 1, 1'b1, 0, 0, 0);
        tick();
        rst_n = 1'b0;
        push("rst_midring", S_IDLE, 1, 1'b0, 1, 6'd0, 6'd0);
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
